// File: rtl/tom_ctl.sv
// Per-frame motion controller for the Tom sprite. Horizontal stepping and a
// ground/air jump machine with integer gravity, all applied once per vblank rise.
module tom_ctl #(
  parameter int X_INIT   = 100,
  parameter int Y_GROUND = 450,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 700,
  parameter int STEP_X   = 4,
  parameter int JUMP_V0  = 12,
  parameter int GRAVITY  = 1,
  parameter int MAX_FALL = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vblnk,
  input  logic       left,
  input  logic       right,
  input  logic       jump,
  input  logic       freeze,
  output logic [9:0] tom_x,
  output logic [9:0] tom_y,
  output logic       facing_left,
  output logic       on_ground,
  output logic       frame_tick
);

  typedef enum logic {GROUND = 1'b0, AIR = 1'b1} state_e;

  localparam logic [9:0]         X_INIT_U     = 10'(X_INIT);
  localparam logic [9:0]         Y_GROUND_U   = 10'(Y_GROUND);
  localparam logic [9:0]         JUMP_V0_U    = 10'(JUMP_V0);
  localparam logic signed [10:0] X_MIN_S      = 11'(X_MIN);
  localparam logic signed [10:0] X_MAX_S      = 11'(X_MAX);
  localparam logic signed [10:0] STEP_X_S     = 11'(STEP_X);
  localparam logic signed [10:0] Y_GROUND_S   = 11'(Y_GROUND);
  localparam logic signed [5:0]  JUMP_V0_S    = 6'(JUMP_V0);
  localparam logic signed [5:0]  GRAVITY_S    = 6'(GRAVITY);
  localparam logic signed [5:0]  MAX_FALL_NEG = 6'(-MAX_FALL);

  state_e             state_q, state_d;
  logic               vblnk_q, vblnk_d;
  logic               seen_low_q, seen_low_d;
  logic               jump_lat_q, jump_lat_d;
  logic [9:0]         x_q, x_d;
  logic [9:0]         y_q, y_d;
  logic signed [5:0]  vy_q, vy_d;
  logic               facing_q, facing_d;
  logic               on_ground_q, on_ground_d;
  logic               tick_q, tick_d;

  logic               tick;
  logic               jump_now;
  logic signed [10:0] x_left, x_right, y_nxt;
  logic signed [5:0]  vy_dec, vy_nxt;

  always_comb begin
    // A rise only counts once vblnk has been seen low since reset, so a
    // vblnk already high at reset release cannot fake a frame tick.
    tick     = vblnk & ~vblnk_q & seen_low_q;
    jump_now = jump_lat_q | jump;

    x_left  = $signed({1'b0, x_q}) - STEP_X_S;
    x_right = $signed({1'b0, x_q}) + STEP_X_S;
    y_nxt   = $signed({1'b0, y_q}) - $signed({{5{vy_q[5]}}, vy_q});
    vy_dec  = vy_q - GRAVITY_S;
    vy_nxt  = (vy_dec < MAX_FALL_NEG) ? MAX_FALL_NEG : vy_dec;

    vblnk_d    = vblnk;
    seen_low_d = seen_low_q | ~vblnk;
    jump_lat_d = tick ? 1'b0 : jump_now;
    tick_d     = tick;
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    vy_d       = vy_q;
    facing_d   = facing_q;

    if (tick && !freeze) begin
      if (left && !right) begin
        x_d      = (x_left < X_MIN_S) ? X_MIN_S[9:0] : x_left[9:0];
        facing_d = 1'b1;
      end else if (right && !left) begin
        x_d      = (x_right > X_MAX_S) ? X_MAX_S[9:0] : x_right[9:0];
        facing_d = 1'b0;
      end

      case (state_q)
        GROUND: begin
          if (jump_now) begin
            vy_d    = JUMP_V0_S;
            y_d     = y_q - JUMP_V0_U;
            state_d = AIR;
          end else begin
            y_d  = Y_GROUND_U;
            vy_d = '0;
          end
        end
        AIR: begin
          if (y_nxt[10]) begin
            y_d  = '0;
            vy_d = '0;
          end else if (y_nxt >= Y_GROUND_S) begin
            y_d     = Y_GROUND_U;
            vy_d    = '0;
            state_d = GROUND;
          end else begin
            y_d  = y_nxt[9:0];
            vy_d = vy_nxt;
          end
        end
        default: state_d = GROUND;
      endcase
    end

    on_ground_d = (state_d == GROUND);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= GROUND;
      vblnk_q     <= 1'b0;
      seen_low_q  <= 1'b0;
      jump_lat_q  <= 1'b0;
      x_q         <= X_INIT_U;
      y_q         <= Y_GROUND_U;
      vy_q        <= '0;
      facing_q    <= 1'b0;
      on_ground_q <= 1'b1;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vblnk_q     <= vblnk_d;
      seen_low_q  <= seen_low_d;
      jump_lat_q  <= jump_lat_d;
      x_q         <= x_d;
      y_q         <= y_d;
      vy_q        <= vy_d;
      facing_q    <= facing_d;
      on_ground_q <= on_ground_d;
      tick_q      <= tick_d;
    end
  end

  assign tom_x       = x_q;
  assign tom_y       = y_q;
  assign facing_left = facing_q;
  assign on_ground   = on_ground_q;
  assign frame_tick  = tick_q;

endmodule

// File: tb/tb_tom_ctl.sv
// Bench for tom_ctl: directed frame scenarios followed by random frames, each
// checked against a frame-level integer model of the sprite motion rules.
module tb_tom_ctl;

  logic       clk = 1'b0;
  logic       rst, vblnk, left, right, jump, freeze;
  logic [9:0] tom_x, tom_y;
  logic       facing_left, on_ground, frame_tick;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, in plain integers.
  int m_x, m_y, m_vy, m_face;
  bit m_air, m_pend;

  tom_ctl dut (
    .clk(clk), .rst(rst), .vblnk(vblnk), .left(left), .right(right),
    .jump(jump), .freeze(freeze), .tom_x(tom_x), .tom_y(tom_y),
    .facing_left(facing_left), .on_ground(on_ground), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_x = 100; m_y = 450; m_vy = 0; m_face = 0; m_air = 0; m_pend = 0;
  endtask

  // One frame of motion from the behavioural rules.
  task automatic model_tick(input bit l, input bit r, input bit fz, input bit j_now);
    int yn;
    if (fz) return;
    if (l && !r) begin
      m_x = (m_x - 4 < 0) ? 0 : m_x - 4;
      m_face = 1;
    end else if (r && !l) begin
      m_x = (m_x + 4 > 700) ? 700 : m_x + 4;
      m_face = 0;
    end
    if (!m_air) begin
      if (j_now) begin
        m_vy = 12; m_y = m_y - 12; m_air = 1;
      end else begin
        m_y = 450; m_vy = 0;
      end
    end else begin
      yn = m_y - m_vy;
      if (yn < 0) begin
        m_y = 0; m_vy = 0;
      end else if (yn >= 450) begin
        m_y = 450; m_vy = 0; m_air = 0;
      end else begin
        m_y = yn;
        m_vy = (m_vy - 1 < -12) ? -12 : m_vy - 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, "_x"}, int'(tom_x), m_x);
    check_eq({tag, "_y"}, int'(tom_y), m_y);
    check_eq({tag, "_face"}, int'(facing_left), m_face);
    check_eq({tag, "_gnd"}, int'(on_ground), int'(!m_air));
  endtask

  // One frame: vblnk low for a few cycles, then a rising edge.
  // jump_at < 0: no jump pulse; jump_at >= nlow: pulse in the tick cycle.
  task automatic run_frame(input bit l, input bit r, input bit fz, input int jump_at);
    int  nlow;
    bit  j_now;
    nlow  = $urandom_range(2, 5);
    left  = l; right = r; freeze = fz; vblnk = 1'b0;
    for (int i = 0; i < nlow; i++) begin
      jump = (jump_at == i);
      if (jump) m_pend = 1;
      cyc();
    end
    vblnk = 1'b1;
    jump  = (jump_at >= nlow);
    @(negedge clk);
    check_eq("pre_tick_ft", int'(frame_tick), 0);
    j_now  = m_pend | jump;
    m_pend = 0;
    model_tick(l, r, fz, j_now);
    cyc();
    jump = 1'b0;
    @(negedge clk);
    check_eq("tick_ft", int'(frame_tick), 1);
    check_all("frame");
    cyc();
    @(negedge clk);
    check_eq("ft_one_cycle", int'(frame_tick), 0);
    check_eq("hold_y", int'(tom_y), m_y);
  endtask

  initial begin
    rst = 1'b1; vblnk = 1'b0; left = 1'b0; right = 1'b0; jump = 1'b0; freeze = 1'b0;
    model_reset();
    repeat (3) cyc();
    rst = 1'b0;
    @(negedge clk);
    check_all("reset");
    check_eq("reset_ft", int'(frame_tick), 0);

    repeat (3) run_frame(0, 0, 0, -1);
    repeat (5) run_frame(0, 1, 0, -1);
    check_eq("right5_x", int'(tom_x), 120);
    repeat (2) run_frame(1, 1, 0, -1);
    check_eq("both_x", int'(tom_x), 120);

    rst = 1'b1; cyc(); rst = 1'b0; model_reset();
    repeat (30) run_frame(1, 0, 0, -1);
    check_eq("left_floor_x", int'(tom_x), 0);
    repeat (180) run_frame(0, 1, 0, -1);
    check_eq("right_ceil_x", int'(tom_x), 700);

    // Full jump arc with an ignored mid-air request.
    run_frame(0, 0, 0, 1);
    check_eq("jump_y", int'(tom_y), 438);
    for (int t = 2; t <= 30; t++) run_frame(0, 0, 0, (t == 20) ? 0 : -1);
    check_eq("landed_gnd", int'(on_ground), 1);

    // Freeze mid-air, with a jump pulse that must be discarded.
    run_frame(0, 0, 0, 9);
    repeat (5) run_frame(1, 0, 0, -1);
    repeat (4) run_frame(0, 1, 1, 0);
    repeat (25) run_frame(0, 0, 0, -1);

    // Reset while airborne, with a pending jump request.
    run_frame(0, 1, 0, 0);
    repeat (4) run_frame(0, 0, 0, -1);
    jump = 1'b1; cyc(); jump = 1'b0;
    rst = 1'b1; vblnk = 1'b1;
    cyc();
    model_reset();
    @(negedge clk);
    check_all("rst_air");
    check_eq("rst_air_ft", int'(frame_tick), 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clk);
      check_eq("no_spurious_ft", int'(frame_tick), 0);
      check_eq("no_spurious_y", int'(tom_y), 450);
    end
    run_frame(0, 0, 0, -1);
    check_eq("latch_cleared_gnd", int'(on_ground), 1);

    for (int f = 0; f < 300; f++) begin
      run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
